// File: rtl/registers_tx_block.sv
// registers_tx_block
//   Readback transmitter for the configuration register bus. It snoops every
//   register write and keeps a shadow copy of registers 0..NUM_REGS-1. When
//   a readback is requested, it sends all shadow registers as one framed
//   byte stream. The stream is one of the byte sources for tx_protocol.
//
//   Frame layout: HEADER_BYTE, NUM_REGS, then one group of three bytes per
//   register i: {i, shadow[i][7:0], shadow[i][15:8]}.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   register_addr  in   register bus address
//   register_data  in   register bus write data
//   register_rdy   in   register bus write strobe (one cycle)
//   rqst_readback  in   readback request pulse
//   tx_data        out  byte presented to tx_protocol
//   tx_rdy         out  tx_data valid
//   tx_eof         out  last byte of the frame (qualified by tx_rdy)
//   tx_ack         in   byte consumed (one-cycle pulse)
//   busy           out  frame in progress or a request pending
module registers_tx_block #(
  parameter int         REG_ADDR_WIDTH = 5,
  parameter int         REG_DATA_WIDTH = 16,
  parameter int         TX_DATA_WIDTH  = 8,
  parameter int         NUM_REGS       = 16,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      rqst_readback,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [TX_DATA_WIDTH-1:0] COUNT_BYTE = TX_DATA_WIDTH'(NUM_REGS);
  localparam logic [REG_ADDR_WIDTH:0] NUM_REGS_EXT = (REG_ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    ADDR,
    DLO,
    DHI
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic [IDX_W-1:0]           r_index;
  logic [IDX_W-1:0]           w_nextIdx;
  logic                       r_pending;
  logic                       w_nextPending;
  logic [REG_DATA_WIDTH-1:0]  r_word;
  logic [REG_DATA_WIDTH-1:0]  r_shadow [NUM_REGS];
  logic                       r_txRdy;
  logic                       r_txEof;
  logic [TX_DATA_WIDTH-1:0]   r_txData;
  logic                       w_nextRdy;
  logic                       w_nextEof;
  logic [TX_DATA_WIDTH-1:0]   w_nextData;
  logic                       w_accept;
  logic                       w_wrHit;
  logic [IDX_W-1:0]           w_wrIdx;
  logic                       w_loadWord;

  // Addresses beyond the shadowed range are dropped; the compare is done one
  // bit wider so NUM_REGS == 2^REG_ADDR_WIDTH is representable.
  assign w_wrHit  = register_rdy && ({1'b0, register_addr} < NUM_REGS_EXT);
  assign w_wrIdx  = register_addr[IDX_W-1:0];
  assign w_accept = tx_ack && r_txRdy;

  // Shadow register file, written in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_wrHit) begin
      r_shadow[w_wrIdx] <= register_data;
    end
  end

  // Next-state logic. Every request, including one arriving in IDLE, goes
  // through the pending flag. This gives a one-cycle request-to-header
  // latency, and requests during a frame are merged into a single follow-up
  // frame.
  always_comb begin
    w_nextState   = r_state;
    w_nextIdx     = r_index;
    w_nextPending = r_pending | rqst_readback;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_nextState   = HDR;
          w_nextIdx     = '0;
          w_nextPending = 1'b0;
        end
      end
      HDR:  if (w_accept) w_nextState = CNT;
      CNT:  if (w_accept) w_nextState = ADDR;
      ADDR: if (w_accept) w_nextState = DLO;
      DLO:  if (w_accept) w_nextState = DHI;
      DHI: begin
        if (w_accept) begin
          if (r_index == LAST_IDX) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = ADDR;
            w_nextIdx   = r_index + 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The outputs are computed from the next state so that they can be
  // registered. The new byte appears in the cycle after an ack, and the
  // byte does not change while it waits to be acked.
  always_comb begin
    w_nextRdy  = (w_nextState != IDLE);
    w_nextEof  = (w_nextState == DHI) && (w_nextIdx == LAST_IDX);
    w_loadWord = (w_nextState == ADDR) && (r_state != ADDR);
    w_nextData = '0;
    case (w_nextState)
      HDR:     w_nextData = TX_DATA_WIDTH'(HEADER_BYTE);
      CNT:     w_nextData = COUNT_BYTE;
      ADDR:    w_nextData = TX_DATA_WIDTH'(w_nextIdx);
      DLO:     w_nextData = TX_DATA_WIDTH'(r_word[7:0]);
      DHI:     w_nextData = TX_DATA_WIDTH'(r_word[15:8]);
      default: w_nextData = '0;
    endcase
  end

  // State, index, pending flag and registered handshake outputs. The word
  // snapshot is taken on entry to ADDR, so both data bytes of a register
  // come from one copy even if the register is written mid-group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_pending <= 1'b0;
      r_word    <= '0;
      r_txRdy   <= 1'b0;
      r_txEof   <= 1'b0;
      r_txData  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_index   <= w_nextIdx;
      r_pending <= w_nextPending;
      r_txRdy   <= w_nextRdy;
      r_txEof   <= w_nextEof;
      r_txData  <= w_nextData;
      if (w_loadWord) begin
        r_word <= r_shadow[w_nextIdx];
      end
    end
  end

  assign tx_rdy  = r_txRdy;
  assign tx_eof  = r_txEof;
  assign tx_data = r_txData;
  assign busy    = (r_state != IDLE) | r_pending;

endmodule

// File: tb/tb_registers_tx_block.sv
// tb_registers_tx_block
//   Self-checking bench for registers_tx_block. A behavioural model keeps the
//   expected shadow contents and builds each expected frame as a byte queue.
//   Every byte received from the DUT is compared against that queue.
module tb_registers_tx_block;

  localparam int NREGS     = 16;
  localparam int FRAME_LEN = 2 + 3 * NREGS;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wrVec_t;

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } posVec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        rqst_readback;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int busyLow = 0;

  logic [15:0] mShadow [NREGS];
  logic [7:0]  expFrame [$];
  logic [7:0]  rxFrame [$];
  wrVec_t      wrTable [2];
  posVec_t     posTable [$];

  always #5 clk = ~clk;

  registers_tx_block dut (
    .clk           (clk),
    .rst           (rst),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .rqst_readback (rqst_readback),
    .tx_data       (tx_data),
    .tx_rdy        (tx_rdy),
    .tx_eof        (tx_eof),
    .tx_ack        (tx_ack),
    .busy          (busy)
  );

  // Compare one value and report it.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle (write and/or request) and update the model.
  task automatic applyStimulus(input logic [4:0] addr, input logic [15:0] data,
                               input logic wr, input logic rqst);
    register_addr = addr;
    register_data = data;
    register_rdy  = wr;
    rqst_readback = rqst;
    @(negedge clk);
    register_rdy  = 1'b0;
    rqst_readback = 1'b0;
    if (wr && (int'(addr) < NREGS)) mShadow[addr] = data;
  endtask

  // Build the expected frame from the model shadow contents.
  task automatic buildFrame();
    expFrame = {};
    expFrame.push_back(8'hA5);
    expFrame.push_back(8'(NREGS));
    for (int i = 0; i < NREGS; i++) begin
      expFrame.push_back(8'(i));
      expFrame.push_back(mShadow[i][7:0]);
      expFrame.push_back(mShadow[i][15:8]);
    end
  endtask

  // Receive one frame with the given ack delay (negative means random) and
  // compare it with expFrame. Optionally perform a register write while byte
  // wrAt is presented and before it is acked.
  task automatic runFrame(input int ackDelay, input int startLimit, input int wrAt,
                          input logic [4:0] wrAddr, input logic [15:0] wrData);
    int waitCnt;
    int d;
    waitCnt = 0;
    rxFrame = {};
    while (tx_rdy !== 1'b1 && waitCnt < startLimit) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("frame_start_rdy", 32'(tx_rdy), 32'd1);
    if (tx_rdy !== 1'b1) return;
    for (int k = 0; k < expFrame.size(); k++) begin
      rxFrame.push_back(tx_data);
      checkOutput($sformatf("byte%0d_data", k), 32'(tx_data), 32'(expFrame[k]));
      checkOutput($sformatf("byte%0d_rdy", k), 32'(tx_rdy), 32'd1);
      checkOutput($sformatf("byte%0d_eof", k), 32'(tx_eof), 32'(k == expFrame.size() - 1));
      d = (ackDelay < 0) ? int'($urandom_range(0, 3)) : ackDelay;
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        checkOutput($sformatf("byte%0d_hold", k), 32'(tx_data), 32'(expFrame[k]));
      end
      if (k == wrAt) applyStimulus(wrAddr, wrData, 1'b1, 1'b0);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
    end
  endtask

  // Compare received bytes at fixed positions against constant expectations.
  task automatic checkPositions(input string tag);
    for (int i = 0; i < posTable.size(); i++) begin
      checkOutput($sformatf("%s_pos%0d", tag, posTable[i].pos),
                  (posTable[i].pos < rxFrame.size()) ? 32'(rxFrame[posTable[i].pos]) : 32'hFFFF_FFFF,
                  32'(posTable[i].exp));
    end
  endtask

  initial begin
    register_addr = '0;
    register_data = '0;
    register_rdy  = 1'b0;
    rqst_readback = 1'b0;
    tx_ack        = 1'b0;
    for (int i = 0; i < NREGS; i++) mShadow[i] = '0;
    wrTable[0] = '{addr: 5'd3,  data: 16'hBEEF};
    wrTable[1] = '{addr: 5'd20, data: 16'h1234};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdy",  32'(tx_rdy),  32'd0);
    checkOutput("reset_eof",  32'(tx_eof),  32'd0);
    checkOutput("reset_data", 32'(tx_data), 32'd0);
    checkOutput("reset_busy", 32'(busy),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Default frame, ack every cycle, with request-to-header latency checked.
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("latency_rdy_early", 32'(tx_rdy), 32'd0);
    checkOutput("latency_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("latency_rdy", 32'(tx_rdy), 32'd1);
    checkOutput("latency_hdr", 32'(tx_data), 32'hA5);
    buildFrame();
    runFrame(0, 0, -1, 5'd0, 16'd0);
    posTable = '{'{0, 8'hA5}, '{1, 8'h10}, '{2, 8'h00}, '{5, 8'h01},
                 '{47, 8'h0F}, '{48, 8'h00}, '{49, 8'h00}};
    checkPositions("f1");
    checkOutput("f1_end_rdy",  32'(tx_rdy), 32'd0);
    checkOutput("f1_end_busy", 32'(busy),   32'd0);

    // Table of writes (one out of range), then a stray ack while idle.
    for (int i = 0; i < 2; i++) applyStimulus(wrTable[i].addr, wrTable[i].data, 1'b1, 1'b0);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray_ack_rdy",  32'(tx_rdy), 32'd0);
    checkOutput("stray_ack_busy", 32'(busy),   32'd0);
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    runFrame(0, 3, -1, 5'd0, 16'd0);
    posTable = '{'{11, 8'h03}, '{12, 8'hEF}, '{13, 8'hBE}, '{14, 8'h04}, '{15, 8'h00}, '{16, 8'h00}};
    checkPositions("f2");

    // Slow consumer: ack five cycles after each byte appears.
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    runFrame(5, 3, -1, 5'd0, 16'd0);

    // Write to register 5 between the DLO and DHI acks of index 5.
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    runFrame(0, 3, 19, 5'd5, 16'h1111);
    posTable = '{'{17, 8'h05}, '{18, 8'h00}, '{19, 8'h00}};
    checkPositions("snap_old");
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    runFrame(0, 3, -1, 5'd0, 16'd0);
    posTable = '{'{17, 8'h05}, '{18, 8'h11}, '{19, 8'h11}};
    checkPositions("snap_new");

    // Two requests during a frame produce exactly one follow-up frame.
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    busyLow = 0;
    fork
      runFrame(0, 3, -1, 5'd0, 16'd0);
      begin
        repeat (10) @(negedge clk);
        applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
        repeat (7) @(negedge clk);
        applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
      end
      begin
        repeat (FRAME_LEN - 5) begin
          @(negedge clk);
          if (busy !== 1'b1) busyLow++;
        end
      end
    join
    checkOutput("pend_busy_throughout", 32'(busyLow), 32'd0);
    checkOutput("pend_gap_rdy",  32'(tx_rdy), 32'd0);
    checkOutput("pend_gap_busy", 32'(busy),   32'd1);
    @(negedge clk);
    checkOutput("pend_start_rdy", 32'(tx_rdy),  32'd1);
    checkOutput("pend_start_hdr", 32'(tx_data), 32'hA5);
    runFrame(0, 0, -1, 5'd0, 16'd0);
    repeat (5) @(negedge clk);
    checkOutput("pend_single_rdy",  32'(tx_rdy), 32'd0);
    checkOutput("pend_single_busy", 32'(busy),   32'd0);

    // Random writes, a write together with a request, and random ack gaps.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) begin
        applyStimulus(5'($urandom_range(0, 31)), 16'($urandom), 1'b1, 1'b0);
      end
      applyStimulus(5'($urandom_range(0, NREGS - 1)), 16'($urandom), 1'b1, 1'b1);
      buildFrame();
      runFrame(-1, 3, -1, 5'd0, 16'd0);
    end

    // Asynchronous reset while index 7 is on the bus.
    applyStimulus(5'd7, 16'hA5A5, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 23; k++) begin
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
    end
    checkOutput("abort_pre_data", 32'(tx_data), 32'h07);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_rdy",  32'(tx_rdy),  32'd0);
    checkOutput("abort_eof",  32'(tx_eof),  32'd0);
    checkOutput("abort_busy", 32'(busy),    32'd0);
    checkOutput("abort_data", 32'(tx_data), 32'd0);
    for (int i = 0; i < NREGS; i++) mShadow[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(5'd0, 16'd0, 1'b0, 1'b1);
    buildFrame();
    runFrame(0, 3, -1, 5'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run in case the DUT stalls.
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/registers_tx_block.md
Name: registers_tx_block

Overview:
- Readback transmitter: the other direction of registers_rx_block.
- Snoops the register bus (register_addr/data/rdy) and keeps a shadow copy of every configuration register.
- On a readback request, serialises all shadow registers as one framed byte stream.
- That stream is a fourth source for tx_protocol (data/rdy/eof/ack), so the host can verify its configuration.

Parameters:
- REG_ADDR_WIDTH, 5, register bus address width.
- REG_DATA_WIDTH, 16, register bus data width; fixed at 16, sent as two bytes.
- TX_DATA_WIDTH, 8, output byte width.
- NUM_REGS, 16, shadowed addresses 0..NUM_REGS-1; must be between 1 and 2^REG_ADDR_WIDTH.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock (clk_100M domain).
- rst  in  1  asynchronous, active-low reset.
- register_addr  in  REG_ADDR_WIDTH  register bus address.
- register_data  in  REG_DATA_WIDTH  register bus data.
- register_rdy  in  1  register bus write strobe, one cycle.
- rqst_readback  in  1  readback request pulse.
- tx_data  out  TX_DATA_WIDTH  byte to tx_protocol.
- tx_rdy  out  1  tx_data valid.
- tx_eof  out  1  last byte of frame, valid with tx_rdy.
- tx_ack  in  1  byte consumed, one-cycle pulse from tx_protocol.
- busy  out  1  frame in progress or pending.

Behaviour:
- Reset (rst=0, async):
  - tx_rdy=0, tx_eof=0, tx_data=0, busy=0.
  - State IDLE; pending flag cleared; all shadow registers = 0.
  - Reset mid-frame aborts the frame; no eof is emitted.
- Shadow writes:
  - When register_rdy=1 and register_addr<NUM_REGS, shadow[register_addr] <= register_data on the next edge.
  - Addresses >= NUM_REGS are ignored.
  - Writes are accepted in every state.
- Frame format, 2+3*NUM_REGS bytes (50 at default):
  - HEADER_BYTE.
  - NUM_REGS[7:0].
  - Then for i=0..NUM_REGS-1: i (zero-extended to 8 bits), shadow[i][7:0], shadow[i][15:8].
- States: IDLE, HDR, CNT, ADDR, DLO, DHI.
  - IDLE: if rqst_readback or pending, go to HDR next cycle, clear pending, reset index to 0.
  - HDR -> CNT on ack.
  - CNT -> ADDR on ack.
  - ADDR -> DLO on ack. On entering ADDR, shadow[index] is latched into a 16-bit word register, so both data bytes come from one snapshot (no tearing).
  - DLO -> DHI on ack.
  - DHI on ack: if index==NUM_REGS-1, go to IDLE; otherwise increment index and go to ADDR.
- Handshake:
  - tx_rdy is a registered output, high in every non-IDLE state.
  - tx_data is stable while tx_rdy=1 and changes only in the cycle after an ack.
  - On ack the next byte is presented in the following cycle: tx_rdy stays high, tx_data is updated. No idle gap is required.
  - tx_ack while tx_rdy=0 is ignored.
  - tx_eof=1 only in DHI of the last index; it drops with tx_rdy when that byte is acked.
- Latency: rqst_readback sampled in IDLE at edge t -> tx_rdy=1 with HEADER_BYTE after edge t+1.
- Request during a frame: sets pending (one deep; further requests merged). A new frame starts the cycle after the last ack (one IDLE cycle).
- Simultaneous events:
  - Write to shadow[i] while i is in DLO/DHI: transmitted bytes come from the snapshot; the shadow updates for the next frame.
  - Write and rqst_readback in the same cycle in IDLE: the frame contains the new value, because the snapshot is taken at ADDR ≥2 cycles later.
- busy = (state!=IDLE) | pending.

Test Plan:
- Reset, then rqst_readback with ack every cycle -> 50 bytes: A5, 10, 00,00,00, 01,00,00, ... 0F,00,00; tx_eof only on byte 50.
- Write addr 3 = 16'hBEEF and addr 20 = 16'h1234, then readback -> bytes 12..14 = 03,EF,BE; addr 20 ignored; no other value changes.
- Ack delayed 5 cycles per byte -> tx_data holds each byte unchanged across the wait; total frame time ≈ 50*6 cycles; a stray ack while tx_rdy=0 is ignored.
- Write addr 5 = 16'h1111 between the DLO and DHI acks of index 5 -> transmitted bytes 05,(old lo),(old hi); the next frame shows 11,11.
- Two rqst_readback pulses during a frame -> exactly one extra frame, starting one cycle after the first frame's eof byte is acked; busy high throughout.
- Drive rst=0 asynchronously mid-frame (index 7) -> tx_rdy/tx_eof drop without a clock edge; after release, readback returns all zero data.
